// File: rtl/hanoi_solver.sv
// Iterative Tower-of-Hanoi move generator: moves N discs from peg A to peg B,
// offering one legal move per valid/ready handshake.
module hanoi_solver #(
  parameter int N  = 5,
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          move_ready,
  output logic          move_valid,
  output logic [1:0]    from,
  output logic [1:0]    to,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] move_count
);

  localparam int TW = 5;
  localparam logic [CW-1:0] LAST = CW'((64'd1 << N) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OFFER, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [N:1][1:0] pos;
  logic [1:0]      d1, nxt1, pa, pb, calc_from, calc_to;
  logic [TW-1:0]   ta, tb, src_top;
  logic            accept;

  // Empty peg reports N+1 so any real disc compares smaller.
  function automatic logic [TW-1:0] top_of(input logic [N:1][1:0] p, input logic [1:0] peg);
    logic [TW-1:0] t;
    t = TW'(N + 1);
    for (int d = N; d >= 1; d--)
      if (p[d] == peg) t = TW'(d);
    return t;
  endfunction

  always_comb begin
    d1 = pos[1];
    if (N % 2 == 1) nxt1 = (d1 == 2'd2) ? 2'd0 : d1 + 2'd1;
    else            nxt1 = (d1 == 2'd0) ? 2'd2 : d1 - 2'd1;
    case (d1)
      2'd0:    begin pa = 2'd1; pb = 2'd2; end
      2'd1:    begin pa = 2'd0; pb = 2'd2; end
      default: begin pa = 2'd0; pb = 2'd1; end
    endcase
    ta = top_of(pos, pa);
    tb = top_of(pos, pb);
    if (move_count[0]) begin
      calc_from = (ta < tb) ? pa : pb;
      calc_to   = (ta < tb) ? pb : pa;
    end else begin
      calc_from = d1;
      calc_to   = nxt1;
    end
    src_top = top_of(pos, from);
    accept  = (state == S_OFFER) && move_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_CALC;
      S_CALC:         state_nxt = S_OFFER;
      S_OFFER:        if (accept) state_nxt = (move_count + 1'b1 == LAST) ? S_DONE : S_CALC;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos        <= '0;
      from       <= 2'd0;
      to         <= 2'd0;
      move_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          pos        <= '0;
          move_count <= '0;
        end
        S_CALC: begin
          from <= calc_from;
          to   <= calc_to;
        end
        S_OFFER: if (accept) begin
          for (int d = 1; d <= N; d++)
            if (TW'(d) == src_top) pos[d] <= to;
          move_count <= move_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign move_valid = (state == S_OFFER);
  assign busy       = (state == S_CALC) || (state == S_OFFER);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_hanoi_solver.sv
// Directed bench for hanoi_solver: four instances (N=3,2,5,4) exercised in turn.
module tb_hanoi_solver;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n, rst4;
  logic start3, start2, start5, start4;
  logic rdy3, rdy2, rdy5, rdy4;
  logic mv3, mv2, mv5, mv4;
  logic [1:0] f3, t3, f2, t2, f5, t5, f4, t4;
  logic busy3, busy2, busy5, busy4, dn3, dn2, dn5, dn4;
  logic [15:0] cnt3, cnt2, cnt5, cnt4;

  int checks = 0;
  int errors = 0;

  hanoi_solver #(.N(3), .CW(16)) u3 (.clock(clock), .reset_n(rst_n), .start(start3), .move_ready(rdy3),
    .move_valid(mv3), .from(f3), .to(t3), .busy(busy3), .done(dn3), .move_count(cnt3));
  hanoi_solver #(.N(2), .CW(16)) u2 (.clock(clock), .reset_n(rst_n), .start(start2), .move_ready(rdy2),
    .move_valid(mv2), .from(f2), .to(t2), .busy(busy2), .done(dn2), .move_count(cnt2));
  hanoi_solver #(.N(5), .CW(16)) u5 (.clock(clock), .reset_n(rst_n), .start(start5), .move_ready(rdy5),
    .move_valid(mv5), .from(f5), .to(t5), .busy(busy5), .done(dn5), .move_count(cnt5));
  hanoi_solver #(.N(4), .CW(16)) u4 (.clock(clock), .reset_n(rst4), .start(start4), .move_ready(rdy4),
    .move_valid(mv4), .from(f4), .to(t4), .busy(busy4), .done(dn4), .move_count(cnt4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic mv_sel(input int w);
    case (w)
      3: return mv3;
      2: return mv2;
      5: return mv5;
      default: return mv4;
    endcase
  endfunction

  task automatic wait_mv(input string tag, input int w);
    int n = 0;
    while (!mv_sel(w) && n < 10) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(mv_sel(w)), 32'd1);
  endtask

  // Independent peg model for the closed-loop N=5 run.
  logic [1:0] hp [1:5];

  function automatic int htop(input logic [1:0] peg);
    int t = 6;
    for (int d = 5; d >= 1; d--) if (hp[d] == peg) t = d;
    return t;
  endfunction

  logic [3:0] exp3 [7] = '{4'b0001, 4'b0010, 4'b0110, 4'b0001, 4'b1000, 4'b1001, 4'b0001};
  logic [3:0] exp2 [3] = '{4'b0010, 4'b0001, 4'b1001};

  initial begin
    rst_n = 1'b0; rst4 = 1'b0;
    start3 = 0; start2 = 0; start5 = 0; start4 = 0;
    rdy3 = 0; rdy2 = 0; rdy5 = 0; rdy4 = 0;
    #2;
    check("rst_valid", 32'(mv3), 0);
    check("rst_fromto", 32'({f3, t3}), 0);
    check("rst_busy_done", 32'({busy3, dn3}), 0);
    check("rst_count", 32'(cnt3), 0);
    @(negedge clock);
    rst_n = 1'b1; rst4 = 1'b1;
    @(negedge clock);

    // N=3, ready tied high, with start latency and bubble checks
    rdy3 = 1;
    start3 = 1; @(negedge clock); start3 = 0;
    check("n3_calc_busy", 32'({busy3, mv3}), 32'b10);
    @(negedge clock);
    check("n3_first_valid", 32'(mv3), 1);
    for (int k = 0; k < 7; k++) begin
      wait_mv("n3_wait", 3);
      check($sformatf("n3_move%0d", k), 32'({f3, t3}), 32'(exp3[k]));
      check($sformatf("n3_cnt%0d", k), 32'(cnt3), 32'(k));
      @(negedge clock);
      if (k < 6) check("n3_bubble", 32'(mv3), 0);
    end
    check("n3_done", 32'(dn3), 1);
    check("n3_final_cnt", 32'(cnt3), 7);
    check("n3_valid_low", 32'(mv3), 0);
    @(negedge clock); @(negedge clock);
    check("n3_stays_done", 32'({dn3, mv3, busy3}), 32'b100);

    // N=3 restart from DONE with backpressure and an ignored start in OFFER
    rdy3 = 0;
    start3 = 1; @(negedge clock); start3 = 0;
    check("n3r_cnt_clear", 32'(cnt3), 0);
    check("n3r_not_done", 32'(dn3), 0);
    for (int k = 0; k < 7; k++) begin
      wait_mv("n3r_wait", 3);
      check($sformatf("n3r_move%0d", k), 32'({f3, t3}), 32'(exp3[k]));
      if (k == 1) begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          check("bp_valid", 32'(mv3), 1);
          check("bp_fromto", 32'({f3, t3}), 32'b0010);
          check("bp_cnt", 32'(cnt3), 1);
        end
      end
      if (k == 3) begin
        start3 = 1; @(negedge clock); start3 = 0;
        check("ign_start_valid", 32'(mv3), 1);
        check("ign_start_move", 32'({f3, t3}), 32'b0001);
        check("ign_start_cnt", 32'(cnt3), 3);
      end
      rdy3 = 1; @(negedge clock); rdy3 = 0;
    end
    check("n3r_done", 32'(dn3), 1);
    check("n3r_cnt", 32'(cnt3), 7);

    // N=2
    rdy2 = 1;
    start2 = 1; @(negedge clock); start2 = 0;
    for (int k = 0; k < 3; k++) begin
      wait_mv("n2_wait", 2);
      check($sformatf("n2_move%0d", k), 32'({f2, t2}), 32'(exp2[k]));
      @(negedge clock);
    end
    check("n2_done", 32'(dn2), 1);
    check("n2_cnt", 32'(cnt2), 3);

    // N=5 closed loop against the peg model
    for (int d = 1; d <= 5; d++) hp[d] = 2'd0;
    rdy5 = 1;
    start5 = 1; @(negedge clock); start5 = 0;
    for (int k = 0; k < 31; k++) begin
      int ts, td;
      wait_mv("n5_wait", 5);
      ts = htop(f5);
      td = htop(t5);
      check($sformatf("n5_legal%0d", k), 32'((f5 != 2'd3) && (t5 != 2'd3) && (f5 != t5) && ts <= 5 && td > ts), 1);
      if (ts <= 5) hp[ts] = t5;
      @(negedge clock);
    end
    check("n5_model_done", 32'(hp[1] == 1 && hp[2] == 1 && hp[3] == 1 && hp[4] == 1 && hp[5] == 1), 1);
    check("n5_done", 32'(dn5), 1);
    check("n5_cnt", 32'(cnt5), 31);

    // N=4 async reset mid-solve
    rdy4 = 1;
    start4 = 1; @(negedge clock); start4 = 0;
    for (int k = 0; k < 6; k++) begin
      wait_mv("n4_wait", 4);
      @(negedge clock);
    end
    check("n4_cnt6", 32'(cnt4), 6);
    #2 rst4 = 1'b0;
    #1;
    check("n4_async_valid", 32'(mv4), 0);
    check("n4_async_state", 32'({busy4, dn4}), 0);
    check("n4_async_fromto", 32'({f4, t4}), 0);
    check("n4_async_cnt", 32'(cnt4), 0);
    @(negedge clock);
    rst4 = 1'b1;
    @(negedge clock);
    check("n4_idle", 32'({busy4, mv4}), 0);
    start4 = 1; @(negedge clock); start4 = 0;
    wait_mv("n4r_wait", 4);
    check("n4_restart_move", 32'({f4, t4}), 32'b0010);
    check("n4_restart_cnt", 32'(cnt4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
